// File: rtl/req_gnt_if.sv
// Request/grant interface adapter: skewed req drive, skewed gnt sample, change and toggle tracking.
// Define REQ_GNT_IF_MON_EN to compile in the grant-wait latency / timeout monitor.
module req_gnt_if #(
   parameter int unsigned W        = 4,
   parameter int unsigned OUT_SKEW = 0,
   parameter int unsigned IN_SKEW  = 1,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         drv_valid,
   input  logic         drv_req,
   output logic         req,
   input  logic [W-1:0] gnt,
   output logic [W-1:0] gnt_smp,
   output logic         gnt_chg,
   output logic [7:0]   req_tog_cnt,
   output logic [7:0]   lat_cnt,
   output logic         timeout
);

   // Catch skew or timeout values the design cannot honour.
   if (OUT_SKEW > 7 || IN_SKEW > 4 || TIMEOUT > 254) begin : g_bad_param
      $error("req_gnt_if: parameter out of range");
   end

   // req_pipe[0] is the command register; the last stage drives req.
   logic         req_pipe [OUT_SKEW+1];
   logic [W-1:0] gnt_pipe [IN_SKEW+1];

   logic         cmd_nxt_c;
   logic         req_nxt_c;
   logic [W-1:0] smp_nxt_c;

   assign cmd_nxt_c = drv_valid ? drv_req : req_pipe[0];

   // Look one edge ahead so toggles and sample changes are recorded at the edge they occur.
   if (OUT_SKEW == 0) begin : g_req_nxt0
      assign req_nxt_c = cmd_nxt_c;
   end else begin : g_req_nxtn
      assign req_nxt_c = req_pipe[OUT_SKEW-1];
   end

   if (IN_SKEW == 0) begin : g_smp_nxt0
      assign smp_nxt_c = gnt;
   end else begin : g_smp_nxtn
      assign smp_nxt_c = gnt_pipe[IN_SKEW-1];
   end

   assign req     = req_pipe[OUT_SKEW];
   assign gnt_smp = gnt_pipe[IN_SKEW];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i <= OUT_SKEW; i++) req_pipe[i] <= 1'b0;
         for (int unsigned i = 0; i <= IN_SKEW; i++)  gnt_pipe[i] <= '0;
         gnt_chg     <= 1'b0;
         req_tog_cnt <= 8'd0;
      end else begin
         req_pipe[0] <= cmd_nxt_c;
         for (int unsigned i = 1; i <= OUT_SKEW; i++) req_pipe[i] <= req_pipe[i-1];
         gnt_pipe[0] <= gnt;
         for (int unsigned i = 1; i <= IN_SKEW; i++)  gnt_pipe[i] <= gnt_pipe[i-1];
         gnt_chg <= (smp_nxt_c != gnt_smp);
         if (req_nxt_c != req) req_tog_cnt <= req_tog_cnt + 8'd1;
      end
   end

`ifdef REQ_GNT_IF_MON_EN
   // Grant-wait monitor: counts cycles with req high and no grant on bit 0.
   logic wait_c;
   assign wait_c = req & ~gnt_smp[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_cnt <= 8'd0;
         timeout <= 1'b0;
      end else if (wait_c) begin
         if (lat_cnt != 8'hFF) lat_cnt <= lat_cnt + 8'd1;
         if (32'(lat_cnt) >= TIMEOUT) timeout <= 1'b1;
      end else begin
         lat_cnt <= 8'd0;
      end
   end
`else
   assign lat_cnt = 8'd0;
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_req_gnt_if.sv
// Randomized + directed bench for req_gnt_if: three skew configurations checked each cycle
// against a history-based reference model.
module tb_req_gnt_if;
   localparam int NI   = 3;
   localparam int HMAX = 4096;
   localparam int TO   = 15;

   int os_t [NI] = '{0, 2, 5};
   int is_t [NI] = '{0, 1, 2};

   logic       clk = 1'b0;
   logic       rst, drv_valid, drv_req;
   logic [3:0] gnt;

   logic       req_o [NI];
   logic [3:0] smp_o [NI];
   logic       chg_o [NI];
   logic [7:0] cnt_o [NI];
   logic [7:0] lat_o [NI];
   logic       to_o  [NI];

   always #5 clk = ~clk;

   req_gnt_if #(.W(4), .OUT_SKEW(0), .IN_SKEW(0), .TIMEOUT(TO)) u0 (
      .clk(clk), .rst(rst), .drv_valid(drv_valid), .drv_req(drv_req), .req(req_o[0]),
      .gnt(gnt), .gnt_smp(smp_o[0]), .gnt_chg(chg_o[0]), .req_tog_cnt(cnt_o[0]),
      .lat_cnt(lat_o[0]), .timeout(to_o[0]));
   req_gnt_if #(.W(4), .OUT_SKEW(2), .IN_SKEW(1), .TIMEOUT(TO)) u1 (
      .clk(clk), .rst(rst), .drv_valid(drv_valid), .drv_req(drv_req), .req(req_o[1]),
      .gnt(gnt), .gnt_smp(smp_o[1]), .gnt_chg(chg_o[1]), .req_tog_cnt(cnt_o[1]),
      .lat_cnt(lat_o[1]), .timeout(to_o[1]));
   req_gnt_if #(.W(4), .OUT_SKEW(5), .IN_SKEW(2), .TIMEOUT(TO)) u2 (
      .clk(clk), .rst(rst), .drv_valid(drv_valid), .drv_req(drv_req), .req(req_o[2]),
      .gnt(gnt), .gnt_smp(smp_o[2]), .gnt_chg(chg_o[2]), .req_tog_cnt(cnt_o[2]),
      .lat_cnt(lat_o[2]), .timeout(to_o[2]));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: input history per edge; outputs derived from delayed history.
   bit       h_rst [HMAX];
   bit       h_cmd [HMAX];
   bit [3:0] h_gnt [HMAX];
   bit       x_req [NI][HMAX];
   bit [3:0] x_smp [NI][HMAX];
   int       x_cnt [NI];
   int       x_lat [NI];
   bit       x_to  [NI];
   int       t = 0;

   function automatic bit rst_in(input int lo, input int hi);
      for (int i = lo; i <= hi; i++)
         if (i < 0 || h_rst[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      bit chg, cond;
      int e_lat, e_to;
      if (t + 1 >= HMAX) begin
         $display("FAIL history: model depth %0d exceeded", HMAX);
         $fatal(1);
      end
      t++;
      h_rst[t] = rst;
      h_gnt[t] = gnt;
      h_cmd[t] = rst ? 1'b0 : (drv_valid ? drv_req : h_cmd[t-1]);
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         x_req[k][t] = rst_in(t - os_t[k], t) ? 1'b0 : h_cmd[t - os_t[k]];
         x_smp[k][t] = rst_in(t - is_t[k], t) ? 4'h0 : h_gnt[t - is_t[k]];
         chg  = !rst && (x_smp[k][t] != x_smp[k][t-1]);
         cond = x_req[k][t-1] && !x_smp[k][t-1][0];
         if (rst) begin
            x_cnt[k] = 0; x_lat[k] = 0; x_to[k] = 1'b0;
         end else begin
            if (x_req[k][t] != x_req[k][t-1]) x_cnt[k] = (x_cnt[k] + 1) % 256;
            if (cond && x_lat[k] >= TO) x_to[k] = 1'b1;
            x_lat[k] = cond ? ((x_lat[k] < 255) ? x_lat[k] + 1 : 255) : 0;
         end
`ifdef REQ_GNT_IF_MON_EN
         e_lat = x_lat[k]; e_to = int'(x_to[k]);
`else
         e_lat = 0; e_to = 0;
`endif
         chk($sformatf("u%0d.req@%0d", k, t),     32'(req_o[k]), 32'(x_req[k][t]));
         chk($sformatf("u%0d.gnt_smp@%0d", k, t), 32'(smp_o[k]), 32'(x_smp[k][t]));
         chk($sformatf("u%0d.gnt_chg@%0d", k, t), 32'(chg_o[k]), 32'(chg));
         chk($sformatf("u%0d.tog_cnt@%0d", k, t), 32'(cnt_o[k]), 32'(x_cnt[k]));
         chk($sformatf("u%0d.lat_cnt@%0d", k, t), 32'(lat_o[k]), 32'(e_lat));
         chk($sformatf("u%0d.timeout@%0d", k, t), 32'(to_o[k]),  32'(e_to));
      end
   endtask

   int first [NI];
   int pulses [NI];

   initial begin
      int exp_to;
      rst = 1'b1; drv_valid = 1'b0; drv_req = 1'b0; gnt = 4'hF;
      h_rst[0] = 1'b1;

      // Reset held two edges with gnt=F, then latency of F to gnt_smp.
      tick(); tick();
      for (int k = 0; k < NI; k++) chk($sformatf("u%0d.rst_smp", k), 32'(smp_o[k]), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < NI; k++) first[k] = 99;
      for (int n = 1; n <= 6; n++) begin
         tick();
         for (int k = 0; k < NI; k++)
            if (first[k] == 99 && smp_o[k] == 4'hF) first[k] = n;
      end
      for (int k = 0; k < NI; k++) chk($sformatf("u%0d.rst_smp_lat", k), 32'(first[k]), 32'(is_t[k] + 1));

      // Output skew: load req=1 and count edges until req rises.
      tick();
      drv_valid = 1'b1; drv_req = 1'b1;
      for (int k = 0; k < NI; k++) first[k] = 99;
      for (int n = 1; n <= 8; n++) begin
         tick();
         drv_valid = 1'b0;
         for (int k = 0; k < NI; k++)
            if (first[k] == 99 && req_o[k] == 1'b1) first[k] = n;
      end
      for (int k = 0; k < NI; k++) chk($sformatf("u%0d.out_skew", k), 32'(first[k]), 32'(os_t[k] + 1));

      // Input skew: gnt 3 -> A, latency and single-cycle change pulse.
      gnt = 4'h3;
      for (int n = 0; n < 5; n++) tick();
      gnt = 4'hA;
      for (int k = 0; k < NI; k++) begin first[k] = 99; pulses[k] = 0; end
      for (int n = 1; n <= 8; n++) begin
         tick();
         for (int k = 0; k < NI; k++) begin
            if (first[k] == 99 && smp_o[k] == 4'hA) first[k] = n;
            if (chg_o[k]) pulses[k]++;
         end
      end
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("u%0d.in_skew", k), 32'(first[k]), 32'(is_t[k] + 1));
         chk($sformatf("u%0d.chg_pulses", k), 32'(pulses[k]), 32'd1);
      end

      // Toggle wrap: 256 toggles from a fresh reset return the count to 0.
      rst = 1'b1; tick(); rst = 1'b0;
      drv_valid = 1'b1; drv_req = 1'b0;
      for (int n = 0; n < 256; n++) begin
         drv_req = ~drv_req;
         tick();
      end
      drv_valid = 1'b0;
      for (int n = 0; n < 7; n++) tick();
      for (int k = 0; k < NI; k++) chk($sformatf("u%0d.tog_wrap", k), 32'(cnt_o[k]), 32'd0);
      drv_valid = 1'b1; drv_req = 1'b1;
      tick();
      drv_valid = 1'b0;
      for (int n = 0; n < 7; n++) tick();
      drv_valid = 1'b1;
      for (int n = 0; n < 4; n++) tick();
      drv_valid = 1'b0;
      for (int n = 0; n < 7; n++) tick();
      for (int k = 0; k < NI; k++) chk($sformatf("u%0d.tog_repeat", k), 32'(cnt_o[k]), 32'd1);

      // Grant-wait monitor: req held high with no grant, then grant arrives, then reset.
      rst = 1'b1; tick(); rst = 1'b0;
      gnt = 4'h0; drv_valid = 1'b1; drv_req = 1'b1;
      tick();
      drv_valid = 1'b0;
      for (int n = 0; n < 30; n++) tick();
`ifdef REQ_GNT_IF_MON_EN
      exp_to = 1;
`else
      exp_to = 0;
`endif
      for (int k = 0; k < NI; k++) chk($sformatf("u%0d.timeout_set", k), 32'(to_o[k]), 32'(exp_to));
      gnt = 4'hF;
      for (int n = 0; n < 10; n++) tick();
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("u%0d.timeout_sticky", k), 32'(to_o[k]), 32'(exp_to));
         chk($sformatf("u%0d.lat_clear", k), 32'(lat_o[k]), 32'd0);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      for (int k = 0; k < NI; k++) chk($sformatf("u%0d.timeout_rst", k), 32'(to_o[k]), 32'd0);

      // Random traffic, biased toward long waits so the monitor is exercised.
      for (int n = 0; n < 600; n++) begin
         rst       = ($urandom_range(0, 63) == 0);
         drv_valid = 1'($urandom_range(0, 1));
         drv_req   = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 3) == 0) gnt = {3'($urandom), 1'($urandom_range(0, 5) == 0)};
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/req_gnt_if.md
REQ_GNT_IF -- requirements
Module: req_gnt_if

Interface
REQ-001 Parameter W, default 4: width of the gnt bus.
REQ-002 Parameter OUT_SKEW, default 0, legal range 0..7: extra clock edges of delay on the req drive path.
REQ-003 Parameter IN_SKEW, default 1, legal range 0..4: extra clock edges of delay on the gnt sample path.
REQ-004 Parameter TIMEOUT, default 15: grant-wait limit in cycles, used by the monitor.
REQ-005 Clocking and reset: one clock, clk; reset is synchronous and active-high, rst.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 drv_valid  input  1  load strobe for a new request value.
REQ-009 drv_req  input  1  request value to drive; taken only when drv_valid=1.
REQ-010 req  output  1  skewed request driven to the design.
REQ-011 gnt  input  W  raw grant from the design.
REQ-012 gnt_smp  output  W  skewed sample of gnt.
REQ-013 gnt_chg  output  1  one-cycle pulse when gnt_smp changes.
REQ-014 req_tog_cnt  output  8  count of req transitions.
REQ-015 lat_cnt  output  8  grant-wait latency counter (monitor).
REQ-016 timeout  output  1  sticky grant-timeout flag (monitor).

Function
REQ-017 Command register: at a rising edge with drv_valid=1, req_cmd loads drv_req; with drv_valid=0, req_cmd holds its value.
REQ-018 req is req_cmd delayed by OUT_SKEW register stages. With OUT_SKEW=0, req equals req_cmd, so a value loaded at edge k is visible after edge k; with OUT_SKEW=N, it is visible after edge k+N.
REQ-019 gnt sampling: gnt is registered at every edge using its pre-edge value. gnt_smp is that register delayed by IN_SKEW further stages, so a gnt value present before edge k appears on gnt_smp after edge k+IN_SKEW.
REQ-020 gnt_chg is 1 for exactly the one cycle after any edge at which gnt_smp takes a new value; it is 0 otherwise.
REQ-021 req_tog_cnt increments by 1 on every edge at which req changes value.
REQ-022 req_tog_cnt wraps from 255 to 0.
REQ-023 A drv_valid carrying the current req_cmd value causes no toggle and no count.
REQ-024 Simultaneous events: a req toggle and a gnt_smp change in the same cycle are both recorded independently.

Reset
REQ-025 With rst=1 at a rising edge, the following clear to 0: req_cmd, every req delay stage, every gnt sample stage, gnt_smp, gnt_chg, req_tog_cnt, lat_cnt and timeout.
REQ-026 Reset has priority over drv_valid.
REQ-027 Reset asserted mid-transfer discards all in-flight skewed values.
REQ-028 In the first cycle after reset release, gnt_chg=0.

Configuration
REQ-029 Macro REQ_GNT_IF_MON_EN, when defined, compiles in the grant monitor described in REQ-030 to REQ-032.
REQ-030 While req=1 and gnt_smp[0]=0, lat_cnt increments each edge, saturating at 255.
REQ-031 lat_cnt clears to 0 when req=0 or gnt_smp[0]=1.
REQ-032 timeout sets to 1 at the edge where lat_cnt would exceed TIMEOUT and stays 1 until rst.
REQ-033 When REQ_GNT_IF_MON_EN is undefined, the lat_cnt and timeout ports remain present and are tied to 0, and no monitor logic exists.

Verification
REQ-034 Reset: hold rst for 2 edges with gnt=4'hF -> all outputs 0; after release, gnt_smp=4'hF at IN_SKEW+1 edges.
REQ-035 Output skew: OUT_SKEW in {0,2,5}, drv_valid=1 and drv_req=1 at edge 10 -> req rises after edge 10, 12 and 15 respectively.
REQ-036 Input skew: IN_SKEW in {0,1,2}, gnt changes 4'h3->4'hA between edges 20 and 21 -> gnt_smp=4'hA after edge 21, 22 and 23 respectively; gnt_chg is high for exactly one cycle.
REQ-037 Toggle wrap: 256 req toggles -> req_tog_cnt=0; a repeated drv_req=1 while req=1 -> count unchanged.
REQ-038 Monitor (macro defined, TIMEOUT=15): req=1 with gnt held at 0 -> lat_cnt reaches 15, timeout=1 on the next edge and stays 1 after gnt rises, until rst.
REQ-039 Macro undefined: run the same stimulus as REQ-038 -> lat_cnt=0 and timeout=0 throughout.
